// File: rtl/soc1_ram_loader.sv
// Byte-stream to 32-bit RAM loader: packs bytes little-endian into words, writes each
// completed word once, tracks a 16-bit checksum and flags writes that would run past the RAM.
module soc1_ram_loader #(
    parameter int DEPTH  = 25000,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [16:0]       byte_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widened by one bit so the comparison cannot alias when DEPTH fills the address space.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [16:0]       remaining_q, remaining_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              error_q, error_d;
    logic              in_ready_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              at_last_addr;

    assign at_last_addr = ({1'b0, addr_q} == LAST_ADDR);

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        checksum_d  = checksum_q;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = byte_count;
                    lane_d      = 2'd0;
                    be_d        = 4'd0;
                    wdata_d     = 32'd0;
                    checksum_d  = 16'd0;
                    error_d     = 1'b0;
                    state_d     = (byte_count == 17'd0) ? DONE : FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (in_valid) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = in_data;
                    be_d[lane_q]                   = 1'b1;
                    remaining_d                    = remaining_q - 17'd1;
                    checksum_d                     = checksum_q + {8'd0, in_data};
                    lane_d                         = lane_q + 2'd1;
                    if ((lane_q == 2'd3) || (remaining_q == 17'd1)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            WRITE: begin
                lane_d  = 2'd0;
                be_d    = 4'd0;
                wdata_d = 32'd0;
                if (remaining_q == 17'd0) begin
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = DONE;
                end else if (at_last_addr) begin
                    // Bytes remain but the next word would fall outside the RAM.
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and decoded control outputs, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            remaining_q <= 17'd0;
            lane_q      <= 2'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            checksum_q  <= 16'd0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            checksum_q  <= checksum_d;
            error_q     <= error_d;
            in_ready_q  <= (state_d == FILL);
            wr_q        <= (state_d == WRITE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign in_ready   = in_ready_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign chipselect = wr_q;
    assign write      = wr_q;
    assign clken      = 1'b1;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_soc1_ram_loader.sv
// Self-checking bench for soc1_ram_loader: directed vector table, randomized loads
// against a word-level reference model, and a reset-abort sequence.
module tb_soc1_ram_loader;

    localparam int DEPTH  = 25000;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [16:0]       byte_count;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;

    always #5 clk = ~clk;

    soc1_ram_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write), .writedata(writedata),
        .clken(clken), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    typedef struct packed {
        logic [14:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [14:0] base;
        logic [16:0] cnt;
        int          pat;
        int          prob;
        bit          poke;
        int          exp_n;
        logic [15:0] exp_ck;
        bit          exp_err;
        int          exp_dc;
        logic [31:0] exp_w0;
        logic [3:0]  exp_be_last;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    int         done_cnt = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] bytes_a [64];

    always @(negedge clk) begin
        if (write && chipselect) got_q.push_back({address, writedata, byteenable});
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fill_bytes(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0:       bytes_a[i] = 8'(i + 1);
                1:       bytes_a[i] = 8'(8'hAA + 8'h11 * i);
                default: bytes_a[i] = 8'($urandom);
            endcase
        end
    endtask

    // Reference: one write per 4-byte group, little-endian, stopping at the end of RAM.
    task automatic model_load(input logic [14:0] base, input int cnt,
                              output logic [15:0] ck, output bit err);
        wr_t w;
        int  nw;
        int  a;
        exp_q.delete();
        ck  = 16'd0;
        err = 1'b0;
        nw  = (cnt + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            a = int'(base) + wi;
            if (a >= DEPTH) begin
                err = 1'b1;
                break;
            end
            w.addr = 15'(a);
            w.data = 32'd0;
            w.be   = 4'd0;
            for (int k = 0; k < 4; k++) begin
                if (wi * 4 + k < cnt) begin
                    w.data[8*k +: 8] = bytes_a[wi*4+k];
                    w.be[k]          = 1'b1;
                    ck               = ck + 16'(bytes_a[wi*4+k]);
                end
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic run_load(input logic [14:0] base, input logic [16:0] cnt, input int prob,
                            input bit poke, output int done_cyc, output bit rdy_seen);
        int idx;
        int cyc;
        bit seen;
        base_addr  = base;
        byte_count = cnt;
        start      = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        idx      = 0;
        cyc      = 0;
        seen     = 1'b0;
        done_cyc = -1;
        rdy_seen = 1'b0;
        while (!seen && cyc < 400) begin
            start = poke && (cyc == 3);
            if (start) begin
                base_addr  = 15'h7000;
                byte_count = 17'd3;
            end
            in_valid = (idx < int'(cnt)) && ($urandom_range(0, 99) < prob);
            in_data  = in_valid ? bytes_a[idx] : 8'($urandom);
            @(negedge clk);
            if (in_ready) rdy_seen = 1'b1;
            if (in_valid && in_ready) idx++;
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("done_seen", {63'd0, seen}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_load(input int gb, input int db, input logic [15:0] ck, input bit err);
        chk("nwrites", 64'(got_q.size() - gb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gb + i < got_q.size()) chk("write", 64'(got_q[gb+i]), 64'(exp_q[i]));
        end
        chk("model_checksum", 64'(checksum), 64'(ck));
        chk("model_error", 64'(error), 64'(err));
        chk("done_pulses", 64'(done_cnt - db), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] mck;
        bit          merr;
        int          gb;
        int          db;
        int          dc;
        bit          rdy;
        logic [14:0] rbase;
        logic [16:0] rcnt;

        vecs[0] = '{15'h0010, 17'd8,  0, 100, 1'b0, 2, 16'h0024, 1'b0, 10, 32'h04030201, 4'hF};
        vecs[1] = '{15'h0000, 17'd6,  1, 100, 1'b0, 2, 16'h04FB, 1'b0,  8, 32'hDDCCBBAA, 4'h3};
        vecs[2] = '{15'h0007, 17'd0,  0, 100, 1'b0, 0, 16'h0000, 1'b0,  0, 32'h00000000, 4'h0};
        vecs[3] = '{15'd24999, 17'd8, 0, 100, 1'b0, 1, 16'h000A, 1'b1,  5, 32'h04030201, 4'hF};
        vecs[4] = '{15'h0100, 17'd12, 0,  50, 1'b1, 3, 16'h004E, 1'b0, -1, 32'h04030201, 4'hF};
        vecs[5] = '{15'h0005, 17'd1,  1, 100, 1'b0, 1, 16'h00AA, 1'b0,  2, 32'h000000AA, 4'h1};

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        byte_count = 17'd0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_byteenable", 64'(byteenable), 64'd0);
        chk("rst_chipselect", 64'(chipselect), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_writedata", 64'(writedata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        chk("rst_clken", 64'(clken), 64'd1);
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            fill_bytes(vecs[v].pat);
            model_load(vecs[v].base, int'(vecs[v].cnt), mck, merr);
            gb = got_q.size();
            db = done_cnt;
            run_load(vecs[v].base, vecs[v].cnt, vecs[v].prob, vecs[v].poke, dc, rdy);
            check_load(gb, db, mck, merr);
            chk("vec_nwrites", 64'(got_q.size() - gb), 64'(vecs[v].exp_n));
            chk("vec_checksum", 64'(checksum), 64'(vecs[v].exp_ck));
            chk("vec_error", 64'(error), 64'(vecs[v].exp_err));
            chk("vec_ready_seen", 64'(rdy), 64'(vecs[v].cnt != 17'd0));
            if (vecs[v].exp_dc >= 0) chk("vec_done_cycle", 64'(dc), 64'(vecs[v].exp_dc));
            if (vecs[v].exp_n > 0 && got_q.size() >= gb + vecs[v].exp_n) begin
                chk("vec_first_data", 64'(got_q[gb].data), 64'(vecs[v].exp_w0));
                chk("vec_first_addr", 64'(got_q[gb].addr), 64'(vecs[v].base));
                chk("vec_last_be", 64'(got_q[gb+vecs[v].exp_n-1].be), 64'(vecs[v].exp_be_last));
            end
        end

        for (int r = 0; r < 10; r++) begin
            fill_bytes(2);
            if (r % 3 == 0) rbase = 15'(DEPTH - 1 - int'($urandom_range(0, 3)));
            else            rbase = 15'($urandom_range(0, 1000));
            rcnt = 17'($urandom_range(0, 40));
            model_load(rbase, int'(rcnt), mck, merr);
            gb = got_q.size();
            db = done_cnt;
            run_load(rbase, rcnt, int'($urandom_range(30, 100)), r[0], dc, rdy);
            check_load(gb, db, mck, merr);
        end

        // Reset after two bytes of a four-byte load must discard the partial word.
        fill_bytes(0);
        gb         = got_q.size();
        base_addr  = 15'h0003;
        byte_count = 17'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = bytes_a[i];
            @(posedge clk); #1;
        end
        in_data = bytes_a[2];
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_checksum", 64'(checksum), 64'd0);
        chk("abort_byteenable", 64'(byteenable), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("abort_no_write", 64'(got_q.size() - gb), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc1_ram_loader.md
SOC1_RAM_LOADER -- requirements
Module: soc1_ram_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 25000, meaning the number of 32-bit words in the target RAM.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning the width of the RAM word address.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: one-cycle load request, sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W bits: first word address, latched on accepted start.
REQ-007 Port byte_count, input, 17 bits: number of bytes to load, latched on accepted start.
REQ-008 Port in_data, input, 8 bits: stream byte.
REQ-009 Port in_valid, input, 1 bit: in_data valid.
REQ-010 Port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both 1.
REQ-011 Port address, output, ADDR_W bits: RAM word address.
REQ-012 Port byteenable, output, 4 bits: RAM byte lanes.
REQ-013 Port chipselect, output, 1 bit: RAM select.
REQ-014 Port write, output, 1 bit: RAM write strobe.
REQ-015 Port writedata, output, 32 bits: RAM write data.
REQ-016 Port clken, output, 1 bit: RAM clock enable.
REQ-017 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 Port done, output, 1 bit: one-cycle completion pulse.
REQ-019 Port error, output, 1 bit: sticky address-overflow flag, cleared by the next accepted start.
REQ-020 Port checksum, output, 16 bits: modulo-2^16 sum of all bytes accepted in the current load.

Function
REQ-021 The block SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-022 IDLE: start=1 SHALL latch base_addr and byte_count, clear checksum and error, and go to FILL; if byte_count=0 it SHALL go directly to DONE.
REQ-023 FILL: in_ready SHALL be 1; in IDLE, WRITE and DONE, in_ready SHALL be 0.
REQ-024 Bytes SHALL pack little-endian: byte k of the current word goes to writedata[8k+7:8k], and its byteenable bit k is set.
REQ-025 Each accepted byte SHALL decrement the remaining count and add to checksum in the same cycle.
REQ-026 FILL -> WRITE SHALL occur on the cycle after lane 3 is accepted, or after the last byte is accepted (remaining reaches 0).
REQ-027 WRITE: chipselect=write=1 for exactly one cycle, with the current address, writedata and byteenable; a partial final word asserts only its filled lanes.
REQ-028 After WRITE: address+1, lanes and byteenable cleared; next state is DONE if remaining=0, else FILL.
REQ-029 Write latency: the RAM write strobe SHALL occur exactly 1 cycle after the handshake that completes the word.
REQ-030 Overflow: if the next word address would equal DEPTH and bytes remain, the block SHALL set error=1, perform no further writes, and go to DONE.
REQ-031 DONE: done=1 for one cycle, then go to IDLE; checksum and error SHALL hold until the next accepted start.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 clken SHALL be constant 1; chipselect and write SHALL be 0 outside WRITE.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL enter IDLE with in_ready=0, address=0, byteenable=0, chipselect=0, write=0, writedata=0, busy=0, done=0, error=0, checksum=0 and clken=1.
REQ-035 Reset mid-load SHALL abort the load: no write after the reset edge, and partial data discarded.

Verification
REQ-036 base=0x0010, count=8, bytes 01..08 streamed -> writes 0x04030201 @0x0010 and 0x08070605 @0x0011, byteenable=0xF, checksum=0x0024, one done pulse.
REQ-037 base=0x0000, count=6, bytes AA,BB,CC,DD,EE,FF -> write 0xDDCCBBAA be=0xF @0, then write 0x0000FFEE be=0x3 @1.
REQ-038 count=0 -> done 1 cycle after start, no write, in_ready never 1.
REQ-039 base=24999, count=8 -> one write @24999, then error=1, done pulse, no write @25000.
REQ-040 in_valid toggled randomly with count=12 -> 3 writes with correct data; start pulsed while busy ignored; reset after byte 2 of a 4-byte load -> no write, in_ready=0 next cycle.
